i3c_ram_1p: RTL and testbench

Single-port synchronous RAM with per-group write masking, registered read data, read-valid strobe and error flags. It backs the I3C core's Device Address Table (64-bit words, depth `DAT_DEPTH`) and Device Characteristics Table (128-bit words, depth `DCT_DEPTH`). It is driven by the core's memory sink struct and returns data through the core's memory source struct.

---
 rtl/i3c_ram_pkg.sv | 17 +
 rtl/i3c_ram_parity.sv | 35 +++
 rtl/i3c_ram_1p.sv | 143 ++++++++++++++
 tb/tb_i3c_ram_1p.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/i3c_ram_pkg.sv
// Shared definitions for the I3C single-port table RAM.
// Holds the error-flag bit positions and the configuration struct that
// arrives on cfg_i.
package i3c_ram_pkg;

   // Bit positions inside rerror_o.
   localparam int RerrParity = 0;
   localparam int RerrAddr   = 1;

   // cfg_i layout: [0] parity_flip (stores inverted parity on write),
   // [1] rsvd (ignored).
   typedef struct packed {
      logic rsvd;
      logic parity_flip;
   } cfg_t;

endpackage

// File: rtl/i3c_ram_parity.sv
// Per-group even-parity generator and checker for the table RAM.
// Ports:
//   wdata : word being written; one parity bit is produced per group
//   flip  : when set, every generated parity bit is inverted
//   wpar  : generated parity, one bit per DataBitsPerMask-wide group
//   rdata : word read from the array
//   rpar  : parity bits stored alongside rdata
//   err   : high when any group of rdata disagrees with its stored parity
module i3c_ram_parity #(
   parameter int Width           = 64,
   parameter int DataBitsPerMask = 32
) (
   input  logic [Width-1:0]                 wdata,
   input  logic                             flip,
   output logic [Width/DataBitsPerMask-1:0] wpar,
   input  logic [Width-1:0]                 rdata,
   input  logic [Width/DataBitsPerMask-1:0] rpar,
   output logic                             err
);

   localparam int Groups = Width / DataBitsPerMask;

   always_comb begin
      wpar = '0;
      err  = 1'b0;
      for (int g = 0; g < Groups; g++) begin
         // Even parity: the stored bit equals the XOR of the group's data.
         wpar[g] = (^wdata[g*DataBitsPerMask +: DataBitsPerMask]) ^ flip;
         if ((^rdata[g*DataBitsPerMask +: DataBitsPerMask]) != rpar[g]) begin
            err = 1'b1;
         end
      end
   end

endmodule

// File: rtl/i3c_ram_1p.sv
// Single-port synchronous RAM backing the I3C Device Address Table and
// Device Characteristics Table. Per-group write masking, registered read
// data with a one-cycle rvalid_o strobe, and error flags.
//
// Optional feature macro: I3C_RAM_PARITY_EN adds one even-parity bit per
// mask group; cfg_i[0] inverts the stored parity on writes (test hook) and
// reads report a mismatch on rerror_o[0]. Without the macro cfg_i is ignored
// and rerror_o[0] is constant 0.
//
// Ports:
//   clk_i     : clock
//   rst_i     : synchronous active-high reset; clears outputs, suppresses
//               requests, leaves the array contents untouched
//   req_i     : access request, always accepted (no backpressure)
//   write_i   : 1 = write, 0 = read
//   addr_i    : word address; addresses >= Depth are out of range
//   wdata_i   : write data
//   wmask_i   : write mask; group g enabled by bit g*DataBitsPerMask
//   rdata_o   : read data, held until the next read completes
//   rvalid_o  : read response strobe
//   rerror_o  : [0] parity error, [1] address out of range
//   cfg_i     : [0] parity flip, [1] reserved
//
// Read response semantics: a read accepted at clock edge N produces exactly
// one rvalid_o pulse in the cycle after edge N, with rdata_o and rerror_o
// valid in that same cycle; rerror_o is 0 whenever rvalid_o is low.
module i3c_ram_1p
   import i3c_ram_pkg::*;
#(
   parameter int Depth           = 128,
   parameter int Width           = 64,
   parameter int DataBitsPerMask = 32,
   parameter int Aw              = $clog2(Depth)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             req_i,
   input  logic             write_i,
   input  logic [Aw-1:0]    addr_i,
   input  logic [Width-1:0] wdata_i,
   input  logic [Width-1:0] wmask_i,
   output logic [Width-1:0] rdata_o,
   output logic             rvalid_o,
   output logic [1:0]       rerror_o,
   input  logic [1:0]       cfg_i
);

   localparam int Groups = Width / DataBitsPerMask;
   // One extra bit so a Depth that is an exact power of two still compares.
   localparam logic [Aw:0] DepthW = (Aw+1)'(Depth);

   if (Width % DataBitsPerMask != 0) begin : g_bad_cfg
      $fatal(1, "i3c_ram_1p: Width must be a multiple of DataBitsPerMask");
   end

   logic [Width-1:0] mem [Depth];

   logic             addr_ok;
   logic             do_write;
   logic             do_read;
   logic [Width-1:0] rd_word;
   logic             par_err;

   logic [Width-1:0] rdata_q;
   logic             rvalid_q;
   logic [1:0]       rerror_q;

   assign addr_ok  = ({1'b0, addr_i} < DepthW);
   assign do_write = !rst_i && req_i && write_i && addr_ok;
   assign do_read  = req_i && !write_i;
   assign rd_word  = addr_ok ? mem[addr_i] : '0;

   // Data array: no reset, contents survive rst_i.
   always_ff @(posedge clk_i) begin
      for (int g = 0; g < Groups; g++) begin
         if (do_write && wmask_i[g*DataBitsPerMask]) begin
            mem[addr_i][g*DataBitsPerMask +: DataBitsPerMask] <=
               wdata_i[g*DataBitsPerMask +: DataBitsPerMask];
         end
      end
   end

`ifdef I3C_RAM_PARITY_EN
   cfg_t              cfg;
   logic [Groups-1:0] par_mem [Depth];
   logic [Groups-1:0] wpar;
   logic [Groups-1:0] rpar;
   logic              unused_bits;

   assign cfg         = cfg_i;
   assign rpar        = addr_ok ? par_mem[addr_i] : '0;
   assign unused_bits = ^{cfg.rsvd, wmask_i};

   i3c_ram_parity #(
      .Width           (Width),
      .DataBitsPerMask (DataBitsPerMask)
   ) u_parity (
      .wdata (wdata_i),
      .flip  (cfg.parity_flip),
      .wpar  (wpar),
      .rdata (rd_word),
      .rpar  (rpar),
      .err   (par_err)
   );

   // Parity bits follow the same group mask as the data they cover.
   always_ff @(posedge clk_i) begin
      for (int g = 0; g < Groups; g++) begin
         if (do_write && wmask_i[g*DataBitsPerMask]) begin
            par_mem[addr_i][g] <= wpar[g];
         end
      end
   end
`else
   logic unused_bits;

   assign par_err     = 1'b0;
   assign unused_bits = ^{cfg_i, wmask_i};
`endif

   // Read response register. rdata_q only moves on a completed read, so
   // writes never disturb the last returned word.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
         rerror_q <= '0;
      end else begin
         rvalid_q <= do_read;
         rerror_q <= '0;
         if (do_read) begin
            rdata_q              <= rd_word;
            rerror_q[RerrAddr]   <= !addr_ok;
            rerror_q[RerrParity] <= par_err && addr_ok;
         end
      end
   end

   assign rdata_o  = rdata_q;
   assign rvalid_o = rvalid_q;
   assign rerror_o = rerror_q;

endmodule

// File: tb/tb_i3c_ram_1p.sv
// Bench for i3c_ram_1p. Two instances share one stimulus stream: a
// Depth=16 build (every 4-bit address in range) and a Depth=12 build
// (addresses 12..15 out of range). Both are Width=64, DataBitsPerMask=32.
module tb_i3c_ram_1p;
   import i3c_ram_pkg::*;

   localparam int W = 64;
   localparam int G = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          req;
   logic          write;
   logic [3:0]    addr;
   logic [W-1:0]  wdata;
   logic [W-1:0]  wmask;
   logic [1:0]    cfg;

   logic [W-1:0]  rdata  [2];
   logic          rvalid [2];
   logic [1:0]    rerror [2];

   // Reference model: word contents plus, per group, whether the last
   // write stored inverted parity.
   logic [W-1:0]  model_mem  [16];
   logic [1:0]    model_flip [16];

   logic [W+1:0]  exp_q [2][$];
   logic [W-1:0]  last_data [2];
   logic          mon_en = 1'b0;

   int            n_checks = 0;
   int            n_fail   = 0;

   always #5 clk = ~clk;

   i3c_ram_1p #(.Depth(16), .Width(W), .DataBitsPerMask(G)) u_dut16 (
      .clk_i    (clk),
      .rst_i    (rst),
      .req_i    (req),
      .write_i  (write),
      .addr_i   (addr),
      .wdata_i  (wdata),
      .wmask_i  (wmask),
      .rdata_o  (rdata[0]),
      .rvalid_o (rvalid[0]),
      .rerror_o (rerror[0]),
      .cfg_i    (cfg)
   );

   i3c_ram_1p #(.Depth(12), .Width(W), .DataBitsPerMask(G)) u_dut12 (
      .clk_i    (clk),
      .rst_i    (rst),
      .req_i    (req),
      .write_i  (write),
      .addr_i   (addr),
      .wdata_i  (wdata),
      .wmask_i  (wmask),
      .rdata_o  (rdata[1]),
      .rvalid_o (rvalid[1]),
      .rerror_o (rerror[1]),
      .cfg_i    (cfg)
   );

   task automatic check(input string name, input int inst,
                        input logic [W+1:0] act, input logic [W+1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s [depth %0d] got %0h expected %0h",
                  name, (inst == 0) ? 16 : 12, act, exp);
      end
   endtask

   // Expected {rerror, rdata} for a read of address a in a build of the
   // given depth.
   function automatic logic [W+1:0] exp_read(input int depth, input int a);
      logic par;
      if (a >= depth) return {2'b10, {W{1'b0}}};
`ifdef I3C_RAM_PARITY_EN
      par = |model_flip[a];
`else
      par = 1'b0;
`endif
      return {1'b0, par, model_mem[a]};
   endfunction

   task automatic drv_write(input int a, input logic [W-1:0] d,
                            input logic [W-1:0] m, input logic [1:0] c);
      @(negedge clk);
      rst = 1'b0; req = 1'b1; write = 1'b1;
      addr = a[3:0]; wdata = d; wmask = m; cfg = c;
      for (int g = 0; g < W/G; g++) begin
         if (m[g*G]) begin
            model_mem[a][g*G +: G] = d[g*G +: G];
            model_flip[a][g]       = c[0];
         end
      end
   endtask

   task automatic drv_read(input int a);
      @(negedge clk);
      rst = 1'b0; req = 1'b1; write = 1'b0; addr = a[3:0];
      wdata = {$urandom(), $urandom()}; cfg = 2'($urandom_range(0, 3));
      exp_q[0].push_back(exp_read(16, a));
      exp_q[1].push_back(exp_read(12, a));
   endtask

   task automatic drv_idle();
      @(negedge clk);
      rst = 1'b0; req = 1'b0; write = 1'($urandom_range(0, 1));
      addr = 4'($urandom_range(0, 15));
   endtask

   // One reset cycle with a request presented alongside it; the request
   // must have no effect and outputs must come back cleared.
   task automatic reset_with_req(input logic is_write, input int a);
      @(negedge clk);
      rst = 1'b1; req = 1'b1; write = is_write; addr = a[3:0];
      wdata = 64'hDEAD_BEEF_0BAD_F00D; wmask = '1; cfg = 2'b00;
      @(negedge clk);
      rst = 1'b0; req = 1'b0;
      for (int i = 0; i < 2; i++) begin
         check("rvalid after reset", i, {65'd0, rvalid[i]}, '0);
         check("rdata after reset", i, {2'b00, rdata[i]}, '0);
      end
   endtask

   // Outputs clear on any edge that sees reset.
   always @(posedge clk) begin
      if (rst) begin
         last_data[0] = '0;
         last_data[1] = '0;
      end
   end

   always @(negedge clk) begin
      if (mon_en) begin
         for (int i = 0; i < 2; i++) begin
            if (rvalid[i]) begin
               if (exp_q[i].size() == 0) begin
                  check("unexpected rvalid", i, {65'd0, rvalid[i]}, '0);
               end else begin
                  logic [W+1:0] e;
                  e = exp_q[i].pop_front();
                  check("read response", i, {rerror[i], rdata[i]}, e);
                  last_data[i] = e[W-1:0];
               end
            end else begin
               check("rerror while idle", i, {64'd0, rerror[i]}, '0);
               check("rdata hold", i, {2'b00, rdata[i]}, {2'b00, last_data[i]});
            end
         end
      end
   end

   initial begin
      rst = 1'b1; req = 1'b0; write = 1'b0; addr = '0;
      wdata = '0; wmask = '0; cfg = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 2; i++) begin
         check("reset rvalid", i, {65'd0, rvalid[i]}, '0);
         check("reset rdata", i, {2'b00, rdata[i]}, '0);
         check("reset rerror", i, {64'd0, rerror[i]}, '0);
      end
      mon_en = 1'b1;

      // Give every model location a known value.
      for (int a = 0; a < 16; a++) begin
         drv_write(a, {$urandom(), $urandom()}, '1, 2'b00);
      end

      // Full write then read.
      drv_write(3, 64'h1122_3344_5566_7788, '1, 2'b00);
      drv_read(3);
      // Masked write: only the low group changes.
      drv_write(3, 64'hAAAA_AAAA_BBBB_BBBB, 64'h0000_0000_FFFF_FFFF, 2'b00);
      drv_read(3);

      // Reset with a read pending, then with a write pending.
      reset_with_req(1'b0, 3);
      reset_with_req(1'b1, 3);
      drv_read(3);

      // Back-to-back reads.
      drv_read(0);
      drv_read(1);
      drv_read(2);
      drv_idle();

      // Out of range for the Depth=12 build.
      drv_read(13);
      drv_write(13, 64'h5A5A_5A5A_A5A5_A5A5, '1, 2'b00);
      for (int a = 0; a < 16; a++) drv_read(a);

      // Parity test hook on address 5, then a clean rewrite; the
      // reserved cfg bit rides along to show it is ignored.
      drv_write(5, 64'h0123_4567_89AB_CDEF, '1, 2'b01);
      drv_read(5);
      drv_write(5, 64'hFEDC_BA98_7654_3210, '1, 2'b10);
      drv_read(5);

      // Randomized traffic.
      for (int n = 0; n < 400; n++) begin
         int op;
         int a;
         logic [W-1:0] m;
         op = $urandom_range(0, 9);
         a  = $urandom_range(0, 15);
         case ($urandom_range(0, 4))
            0:       m = '1;
            1:       m = 64'h0000_0000_FFFF_FFFF;
            2:       m = 64'hFFFF_FFFF_0000_0000;
            3:       m = '0;
            default: m = {$urandom(), $urandom()};
         endcase
         if (op < 4) begin
            drv_write(a, {$urandom(), $urandom()}, m,
                      {1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0)});
         end else if (op < 9) begin
            drv_read(a);
         end else begin
            drv_idle();
         end
      end

      drv_idle();
      for (int t = 0; t < 10; t++) begin
         if (exp_q[0].size() == 0 && exp_q[1].size() == 0) break;
         drv_idle();
      end
      for (int i = 0; i < 2; i++) begin
         check("responses outstanding", i, W'(exp_q[i].size()), '0);
      end
      mon_en = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
